// File: rtl/cla_adder_sched_if.sv
// Request/result bundle for cla_adder_sched: two requester ports plus the shared result strobe.
// The slave modport is the scheduler side; the master modport is the requester/consumer side.
interface cla_adder_sched_if #(
    parameter int WIDTH = 32
);
    logic             iValid0;
    logic [WIDTH-1:0] iA0;
    logic [WIDTH-1:0] iB0;
    logic             iSub0;
    logic             oReady0;

    logic             iValid1;
    logic [WIDTH-1:0] iA1;
    logic [WIDTH-1:0] iB1;
    logic             iSub1;
    logic             oReady1;

    logic             oValid;
    logic             oTag;
    logic [WIDTH-1:0] oSum;
    logic             oCout;
    logic             oOvf;
    logic             oBusy;

    modport slave (
        input  iValid0, iA0, iB0, iSub0,
        input  iValid1, iA1, iB1, iSub1,
        output oReady0, oReady1,
        output oValid, oTag, oSum, oCout, oOvf, oBusy
    );

    modport master (
        output iValid0, iA0, iB0, iSub0,
        output iValid1, iA1, iB1, iSub1,
        input  oReady0, oReady1,
        input  oValid, oTag, oSum, oCout, oOvf, oBusy
    );
endinterface

// File: rtl/cla_adder_sched.sv
// Round-robin scheduler sharing one 4-bit carry-lookahead slice between two add/sub requesters.
// Optional macro CLA_SCHED_EARLY_EXIT_EN: finish early once all remaining operand bits and carry are zero.
module cla_adder_sched #(
    parameter int WIDTH = 32
) (
    input  logic              iClk,
    input  logic              iRst_n,
    cla_adder_sched_if.slave  bus
);
    localparam int NCH = WIDTH / 4;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             last_grant_reg;
    logic             tag_reg;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             valid_reg, out_tag_reg, out_cout_reg, out_ovf_reg;
    logic [WIDTH-1:0] out_sum_reg;

    logic             grant, handshake, ready0, ready1;
    logic             last_chunk, early_exit, chunk_done;
    logic             sel_sub;

    // Carry-lookahead slice on the current chunk
    logic [CW+1:0]    base;
    logic [3:0]       a_chunk, b_chunk, g, p, s;
    logic [4:0]       c;
    logic [WIDTH-1:0] sum_next;

    assign base    = {cnt_reg, 2'b00};
    assign a_chunk = a_reg[base +: 4];
    assign b_chunk = b_reg[base +: 4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_gp
            assign g[gi] = a_chunk[gi] & b_chunk[gi];
            assign p[gi] = a_chunk[gi] ^ b_chunk[gi];
        end
    endgenerate

    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
    assign s    = p ^ c[3:0];

    always_comb begin
        sum_next = sum_reg;
        sum_next[base +: 4] = s;
    end

    assign last_chunk = (cnt_reg == LAST_CHUNK);

`ifdef CLA_SCHED_EARLY_EXIT_EN
    logic [CW+2:0]    hi_shift;
    logic [WIDTH-1:0] hi_bits;
    assign hi_shift   = {1'b0, base} + (CW+3)'(4);
    assign hi_bits    = (a_reg | b_reg) >> hi_shift;
    // sum_reg is cleared on load, so the untouched upper bits are already zero-filled
    assign early_exit = !last_chunk && (hi_bits == '0) && !c[4];
`else
    assign early_exit = 1'b0;
`endif

    assign chunk_done = last_chunk | early_exit;

    // Round-robin: with both requesting, the one not served last wins
    assign grant   = bus.iValid1 & (~bus.iValid0 | ~last_grant_reg);
    assign sel_sub = grant ? bus.iSub1 : bus.iSub0;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        ready0     = 1'b0;
        ready1     = 1'b0;
        handshake  = 1'b0;
        case (state_reg)
            IDLE: begin
                ready0    = bus.iValid0 & ~grant;
                ready1    = bus.iValid1 & grant;
                handshake = ready0 | ready1;
                if (handshake) state_next = RUN;
            end
            RUN:     if (chunk_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_reg        <= '0;
            carry_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            tag_reg        <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            sum_reg        <= '0;
            valid_reg      <= 1'b0;
            out_tag_reg    <= 1'b0;
            out_sum_reg    <= '0;
            out_cout_reg   <= 1'b0;
            out_ovf_reg    <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            if (handshake) begin
                a_reg          <= grant ? bus.iA1 : bus.iA0;
                b_reg          <= (grant ? bus.iB1 : bus.iB0) ^ {WIDTH{sel_sub}};
                carry_reg      <= sel_sub;
                tag_reg        <= grant;
                last_grant_reg <= grant;
                cnt_reg        <= '0;
                sum_reg        <= '0;
            end else if (state_reg == RUN) begin
                sum_reg   <= sum_next;
                carry_reg <= c[4];
                if (!last_chunk) cnt_reg <= cnt_reg + CW'(1);
                if (chunk_done) begin
                    valid_reg    <= 1'b1;
                    out_sum_reg  <= sum_next;
                    out_cout_reg <= c[4];
                    out_ovf_reg  <= last_chunk & (c[3] ^ c[4]);
                    out_tag_reg  <= tag_reg;
                end
            end
        end
    end

    // Ready is combinational, so gate it with reset to keep every output low while held in reset
    assign bus.oReady0 = ready0 & iRst_n;
    assign bus.oReady1 = ready1 & iRst_n;
    assign bus.oValid  = valid_reg;
    assign bus.oTag    = out_tag_reg;
    assign bus.oSum    = out_sum_reg;
    assign bus.oCout   = out_cout_reg;
    assign bus.oOvf    = out_ovf_reg;
    assign bus.oBusy   = (state_reg != IDLE);
endmodule

// File: tb/tb_cla_adder_sched.sv
// Bench for cla_adder_sched: directed operations with literal expectations plus an arithmetic
// reference model checked against every result strobe.
module tb_cla_adder_sched;
    localparam int WIDTH = 32;
    localparam int NCH   = WIDTH / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_adder_sched_if #(.WIDTH(WIDTH)) bus ();

    cla_adder_sched #(.WIDTH(WIDTH)) dut (
        .iClk  (clk),
        .iRst_n(rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic        tag;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q[$];

    // Reference: plain two's-complement arithmetic, latency from the handshake cycle
    function automatic exp_t model(input logic tag, input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input int t);
        exp_t        e;
        logic [31:0] bb;
        logic [32:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + 33'(sub);
        e.tag  = tag;
        e.sum  = full[31:0];
        e.cout = full[32];
        e.ovf  = sub ? ((a[31] != b[31]) && (full[31] != a[31]))
                     : ((a[31] == b[31]) && (full[31] != a[31]));
        e.due  = t + NCH + 1;
`ifdef CLA_SCHED_EARLY_EXIT_EN
        begin
            bit found = 1'b0;
            for (int k = 0; k < NCH - 1; k++) begin
                longint unsigned mask, low;
                int nb;
                nb   = 4 * (k + 1);
                mask = (64'd1 << nb) - 64'd1;
                low  = (64'(a) & mask) + (64'(bb) & mask) + 64'(sub);
                if (!found && ((64'(a) >> nb) == 0) && ((64'(bb) >> nb) == 0) && ((low >> nb) == 0)) begin
                    found  = 1'b1;
                    e.due  = t + k + 2;
                    e.cout = 1'b0;
                    e.ovf  = 1'b0;
                end
            end
        end
`endif
        return e;
    endfunction

    // Compare process: invariants every cycle, model check on every strobe
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            check("ready_exclusive", 64'(bus.oReady0 & bus.oReady1), 64'd0);
            check("ready_only_idle", 64'((bus.oReady0 | bus.oReady1) & bus.oBusy), 64'd0);
            if (bus.oValid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 64'(bus.oValid), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    $display("result tag=%0d sum=%08h cout=%0d ovf=%0d cycle=%0d (due %0d)",
                             bus.oTag, bus.oSum, bus.oCout, bus.oOvf, cyc, e.due);
                    check("model_cycle", 64'(cyc), 64'(e.due));
                    check("model_tag",   64'(bus.oTag),  64'(e.tag));
                    check("model_sum",   64'(bus.oSum),  64'(e.sum));
                    check("model_cout",  64'(bus.oCout), 64'(e.cout));
                    check("model_ovf",   64'(bus.oOvf),  64'(e.ovf));
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                check("missing_valid", 64'(cyc), 64'(q[0].due));
                void'(q.pop_front());
            end
            if (bus.iValid0 && bus.oReady0) q.push_back(model(1'b0, bus.iA0, bus.iB0, bus.iSub0, cyc));
            if (bus.iValid1 && bus.oReady1) q.push_back(model(1'b1, bus.iA1, bus.iB1, bus.iSub1, cyc));
        end
    end

    task automatic run_op(input string name, input logic req, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf, input int exp_lat);
        int t;
        int lat;
        t   = -1;
        lat = -1;
        @(posedge clk); #1;
        if (req) begin
            bus.iValid1 = 1'b1; bus.iA1 = a; bus.iB1 = b; bus.iSub1 = sub;
        end else begin
            bus.iValid0 = 1'b1; bus.iA0 = a; bus.iB0 = b; bus.iSub0 = sub;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (req ? (bus.iValid1 & bus.oReady1) : (bus.iValid0 & bus.oReady0)) begin
                t = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.iValid0 = 1'b0; bus.iValid1 = 1'b0;
        bus.iA0 = 32'hDEADBEEF; bus.iB0 = 32'hCAFEF00D; bus.iA1 = 32'h5A5A5A5A; bus.iB1 = 32'hA5A5A5A5;
        if (t < 0) begin
            check({name, "_handshake_timeout"}, 64'd1, 64'd0);
            return;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.oValid) begin
                lat = cyc - t;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_sum"},  64'(bus.oSum),  64'(exp_sum));
        check({name, "_cout"}, 64'(bus.oCout), 64'(exp_cout));
        check({name, "_ovf"},  64'(bus.oOvf),  64'(exp_ovf));
        check({name, "_tag"},  64'(bus.oTag),  64'(req));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int n;
        int grants[4];
        int times[4];
        bit seen;

        bus.iValid0 = 1'b0; bus.iA0 = '0; bus.iB0 = '0; bus.iSub0 = 1'b0;
        bus.iValid1 = 1'b0; bus.iA1 = '0; bus.iB1 = '0; bus.iSub1 = 1'b0;

        // Reset state, with a request pending to confirm ready stays low in reset
        repeat (3) @(posedge clk);
        #1;
        bus.iValid0 = 1'b1;
        #1;
        check("rst_valid",  64'(bus.oValid),  64'd0);
        check("rst_busy",   64'(bus.oBusy),   64'd0);
        check("rst_sum",    64'(bus.oSum),    64'd0);
        check("rst_ready0", 64'(bus.oReady0), 64'd0);
        bus.iValid0 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("add_ff_1",   1'b0, 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 9);
        run_op("sub_5_7",    1'b1, 32'd5,        32'd7,        1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 9);
        run_op("sub_7_5",    1'b1, 32'd7,        32'd5,        1'b1, 32'h00000002, 1'b1, 1'b0, 9);
        run_op("add_ripple", 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 9);
        run_op("add_ovf",    1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 9);
        run_op("sub_ovf",    1'b1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 9);

`ifdef CLA_SCHED_EARLY_EXIT_EN
        run_op("ee_3_4",     1'b0, 32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b0, 2);
        run_op("ee_f_1",     1'b0, 32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 1'b0, 3);
        run_op("ee_full",    1'b0, 32'h10000000, 32'h00000000, 1'b0, 32'h10000000, 1'b0, 1'b0, 9);
`endif

        // Reset during chunk 3 of an operation
        @(posedge clk); #1;
        bus.iValid0 = 1'b1; bus.iA0 = 32'h00FF00FF; bus.iB0 = 32'h00010001; bus.iSub0 = 1'b0;
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.iValid0 && bus.oReady0) begin
                t = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        bus.iValid0 = 1'b0;
        check("rst_mid_handshake", 64'(t >= 0), 64'd1);
        for (int i = 0; i < 40 && cyc < t + 4; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        // Both requesters present while reset is held; operands for the round-robin phase
        bus.iValid0 = 1'b1; bus.iA0 = 32'h12345678; bus.iB0 = 32'h0FEDCBA9; bus.iSub0 = 1'b0;
        bus.iValid1 = 1'b1; bus.iA1 = 32'h00000010; bus.iB1 = 32'h00000020; bus.iSub1 = 1'b1;
        #1;
        check("arst_valid",  64'(bus.oValid),  64'd0);
        check("arst_sum",    64'(bus.oSum),    64'd0);
        check("arst_cout",   64'(bus.oCout),   64'd0);
        check("arst_ovf",    64'(bus.oOvf),    64'd0);
        check("arst_tag",    64'(bus.oTag),    64'd0);
        check("arst_busy",   64'(bus.oBusy),   64'd0);
        check("arst_ready",  64'(bus.oReady0 | bus.oReady1), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.oValid) seen = 1'b1;
        end
        check("arst_no_valid", 64'(seen), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Continuous contention from reset release
        n = 0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(negedge clk);
            if (bus.iValid0 && bus.oReady0) begin grants[n] = 0; times[n] = cyc; n++; end
            else if (bus.iValid1 && bus.oReady1) begin grants[n] = 1; times[n] = cyc; n++; end
        end
        @(posedge clk); #1;
        bus.iValid0 = 1'b0; bus.iValid1 = 1'b0;
        check("rr_count", 64'(n), 64'd4);
        if (n == 4) begin
            check("rr_grant0", 64'(grants[0]), 64'd0);
            check("rr_grant1", 64'(grants[1]), 64'd1);
            check("rr_grant2", 64'(grants[2]), 64'd0);
            check("rr_grant3", 64'(grants[3]), 64'd1);
            for (int i = 1; i < 4; i++) check("rr_spacing", 64'(times[i] - times[i-1]), 64'd10);
        end
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.oValid) seen = 1'b1;
        end
        check("rr_last_seen", 64'(seen), 64'd1);
        check("rr_last_sum",  64'(bus.oSum),  64'hFFFFFFF0);
        check("rr_last_cout", 64'(bus.oCout), 64'd0);
        check("rr_last_tag",  64'(bus.oTag),  64'd1);

        repeat (5) @(posedge clk);
        check("queue_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
